instr_loader: RTL and testbench

Program loader that writes 16-bit instructions into the SimpleCPU instruction memory, the write side of the memory the fetch stage reads. It accepts a byte stream (high byte first) over a valid/ready handshake, packs byte pairs into instruction words, and writes them to consecutive addresses from 0. While loading it holds the CPU in reset and reports completion, word count and error status.

---
 rtl/instr_loader_pkg.sv | 22 ++
 rtl/instr_loader.sv | 162 ++++++++++++++++
 tb/tb_instr_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and instruction field positions for the SimpleCPU program loader.
// Used by instr_loader and by the decode stage.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5
  } state_e;

  localparam int OPC_MSB = 15;
  localparam int OP1_MSB = 11;
  localparam int OP2_MSB = 7;

  function automatic logic [15:0] pack_instr(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/instr_loader.sv
// Byte-stream program loader: packs high/low byte pairs into 16-bit words and
// writes them from address 0. Optional trailing checksum byte under LOADER_CHECKSUM_EN.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W:0]   word_count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        hi_q;
  logic              last_q;
  logic              accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  assign accept = in_valid & in_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
      addr_q       <= '0;
      hi_q         <= '0;
      last_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= HI;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            word_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
          end
        end
        HI: begin
          if (accept) begin
            hi_q <= in_data;
`ifdef LOADER_CHECKSUM_EN
            sum_q <= sum_q + in_data;
`endif
            if (in_last) begin
              // Odd-length program: the lone high byte is never written.
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
            end else begin
              state_q <= LO;
            end
          end
        end
        LO: begin
          if (accept) begin
            state_q     <= WR;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= pack_instr(hi_q, in_data);
            last_q      <= in_last;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_q + in_data;
`endif
          end
        end
        WR: begin
          word_count_q <= word_count_q + 1'b1;
          if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_q    <= CHK;
            in_ready_q <= 1'b1;
`else
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else if (addr_q == ADDR_MAX) begin
            // Memory full with more program pending; addr stays put, no wrap.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q    <= HI;
            in_ready_q <= 1'b1;
            addr_q     <= addr_q + 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            state_q    <= DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= (sum_q != in_data);
          end
        end
`endif
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: two instances (ADDR_W=4 and ADDR_W=2)
// checked against a length/arithmetic model of the load. Honors LOADER_CHECKSUM_EN.
module tb_instr_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0;
  logic sel = 1'b0;

  logic rdy4, we4, busy4, done4, err4;
  logic [3:0] addr4;
  logic [15:0] wd4;
  logic [4:0] wc4;
  logic rdy2, we2, busy2, done2, err2;
  logic [1:0] addr2;
  logic [15:0] wd2;
  logic [2:0] wc2;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start & ~sel), .in_valid(in_valid & ~sel),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy4), .mem_we(we4),
    .mem_addr(addr4), .mem_wdata(wd4), .busy(busy4), .done(done4), .err(err4),
    .word_count(wc4)
  );

  instr_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start & sel), .in_valid(in_valid & sel),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy2), .mem_we(we2),
    .mem_addr(addr2), .mem_wdata(wd2), .busy(busy2), .done(done2), .err(err2),
    .word_count(wc2)
  );

  logic rdy_m, we_m, busy_m, done_m, err_m;
  logic [31:0] addr_m, wd_m, wc_m;
  assign rdy_m  = sel ? rdy2 : rdy4;
  assign we_m   = sel ? we2 : we4;
  assign busy_m = sel ? busy2 : busy4;
  assign done_m = sel ? done2 : done4;
  assign err_m  = sel ? err2 : err4;
  assign addr_m = sel ? 32'(addr2) : 32'(addr4);
  assign wd_m   = 32'(sel ? wd2 : wd4);
  assign wc_m   = sel ? 32'(wc2) : 32'(wc4);

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_time[$];
  logic [7:0] prog [64];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (in_valid && rdy_m) acc_cnt = acc_cnt + 1;
    if (we_m) begin
      wr_addr.push_back(int'(addr_m));
      wr_data.push_back(int'(wd_m));
      wr_time.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Present one byte from a negedge until it is taken; returns at the next negedge.
  task automatic push(input logic [7:0] b, input logic l, input int gap, input bit pulse_start);
    for (int g = 0; g < gap; g++) begin
      start = pulse_start && (g == 0);
      @(negedge clk);
      start = 1'b0;
    end
    if (pulse_start && gap == 0) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    for (int n = 0; n < 40 && !rdy_m; n++) @(negedge clk);
    if (!rdy_m) check("accept_timeout", 32'(rdy_m), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // ck_mode: 0 sends the correct checksum, 1 sends a wrong one (checksum builds only).
  task automatic run_load(input bit s, input int n, input bit has_last, input int gap_max,
                          input bit mid_start, input bit ck_mode, input string tag);
    int cap, acc, words, exp_err, sum;
    bit exp_chk;
    sel = s;
    cap = s ? 4 : 16;
    acc = (n < 2 * cap) ? n : 2 * cap;
    words = acc / 2;
    exp_err = has_last ? int'((n > 2 * cap) || (n % 2 == 1)) : 1;
    exp_chk = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    exp_chk = has_last && (exp_err == 0);
`endif
    sum = 0;
    wr_addr.delete(); wr_data.delete(); wr_time.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy_m), 32'd1);
    check({tag, "_ready_after_start"}, 32'(rdy_m), 32'd1);
    acc_cnt = 0;
    for (int i = 0; i < acc; i++) begin
      push(prog[i], has_last && (i == n - 1),
           (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0,
           mid_start && (i == 3));
      sum = (sum + int'(prog[i])) % 256;
    end
    if (acc < n) begin
      in_valid = 1'b1;
      in_data  = prog[acc];
      idle(6);
      in_valid = 1'b0;
      check({tag, "_excess_not_accepted"}, 32'(acc_cnt), 32'(acc));
    end
    if (exp_chk) begin
      push(8'(sum + int'(ck_mode)), 1'($urandom_range(0, 1)), 0, 1'b0);
      exp_err = int'(ck_mode);
    end
    for (int c = 0; c < 20 && !done_m; c++) @(negedge clk);
    check({tag, "_done"}, 32'(done_m), 32'd1);
    check({tag, "_err"}, 32'(err_m), 32'(exp_err));
    check({tag, "_word_count"}, wc_m, 32'(words));
    check({tag, "_busy_done"}, 32'(busy_m), 32'd0);
    check({tag, "_ready_done"}, 32'(rdy_m), 32'd0);
    check({tag, "_writes"}, 32'(wr_addr.size()), 32'(words));
    for (int k = 0; k < words && k < wr_addr.size(); k++) begin
      check({tag, "_addr"}, 32'(wr_addr[k]), 32'(k));
      check({tag, "_data"}, 32'(wr_data[k]), {16'd0, prog[2 * k], prog[2 * k + 1]});
      if (gap_max == 0 && !mid_start && k > 0)
        check({tag, "_spacing"}, 32'(wr_time[k] - wr_time[k - 1]), 32'd3);
    end
    $display("[TB] %s: bytes=%0d words=%0d err=%0d", tag, n, words, exp_err);
  endtask

  initial begin
    // Reset held with random inputs: everything must stay quiet.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start    = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      #1;
      check("rst_ready", 32'(rdy4), 32'd0);
      check("rst_outs", {20'd0, we4, busy4, done4, err4, addr4, wc4, 1'b0},
            32'd0);
      check("rst_wdata", 32'(wd4), 32'd0);
      check("rst_dut2", {27'd0, rdy2, we2, busy2, done2, err2}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    rst = 1'b1;
    idle(2);

    prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'h56;
    prog[3] = 8'h78; prog[4] = 8'h9A; prog[5] = 8'hBC;
    run_load(1'b0, 6, 1'b1, 0, 1'b0, 1'b0, "b2b");

    run_load(1'b0, 1, 1'b1, 0, 1'b0, 1'b0, "odd");

    for (int i = 0; i < 10; i++) prog[i] = 8'(8'h21 + 8'(i * 17));
    run_load(1'b1, 10, 1'b0, 0, 1'b0, 1'b0, "trunc");

    prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'h56;
    prog[3] = 8'h78; prog[4] = 8'h9A; prog[5] = 8'hBC;
    run_load(1'b0, 6, 1'b1, 3, 1'b1, 1'b0, "gaps_midstart");

`ifdef LOADER_CHECKSUM_EN
    prog[0] = 8'h01; prog[1] = 8'h02;
    run_load(1'b0, 2, 1'b1, 0, 1'b0, 1'b0, "ck_good");
    run_load(1'b0, 2, 1'b1, 0, 1'b0, 1'b1, "ck_bad");
`endif

    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 36));
      for (int i = 0; i < n; i++) prog[i] = 8'($urandom);
      run_load(1'b0, n, 1'b1, int'($urandom_range(0, 2)), 1'b0,
               1'($urandom_range(0, 1)), "rand");
    end

    // Reset asserted while waiting for a low byte aborts the load at once.
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push(8'hAA, 1'b0, 0, 1'b0);
    check("lo_busy_before_rst", 32'(busy4), 32'd1);
    rst = 1'b0;
    #1;
    check("lo_rst_busy", 32'(busy4), 32'd0);
    check("lo_rst_ready", 32'(rdy4), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("lo_rst_idle", {29'd0, busy4, rdy4, done4}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lo_rst_restart", 32'(busy4), 32'd1);
    $display("[TB] reset_mid_load: checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
